// File: rtl/commit_ctrl.sv
// Retires ROB head entries: regfile write, store release, mispredict redirect + flush; 1-cycle registered effects.
// Stalls the ROB outside RUN or while the 1-entry skid is full; rdy_i low freezes state and suppresses pulses.
module commit_ctrl #(
   parameter int ROB_IDX_W    = 4,
   parameter int WORD_W       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 rob_commit_en_in,
   input  logic [ROB_IDX_W-1:0] rob_pos_in,
   input  logic [4:0]           rd_in,
   input  logic [WORD_W-1:0]    res_in,
   input  logic                 is_store_in,
   input  logic                 jump_en_in,
   input  logic [WORD_W-1:0]    jump_a_in,
   input  logic                 lsb_store_done_in,
   output logic                 commit_stall_out,
   output logic                 rf_we_out,
   output logic [4:0]           rf_rd_out,
   output logic [WORD_W-1:0]    rf_data_out,
   output logic [ROB_IDX_W-1:0] rf_rob_pos_out,
   output logic                 lsb_store_commit_out,
   output logic                 redirect_en_out,
   output logic [WORD_W-1:0]    redirect_a_out,
   output logic                 clear_branch_out,
   output logic                 skid_overflow_out,
   output logic [31:0]          commit_cnt_out
);

   typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

   typedef struct packed {
      logic [4:0]           rd;
      logic [WORD_W-1:0]    res;
      logic [ROB_IDX_W-1:0] pos;
      logic                 is_store;
      logic                 jump_en;
      logic [WORD_W-1:0]    jump_a;
   } entry_t;

   state_t               state_q, state_d;
   entry_t               skid_q, skid_d, in_ent, cur;
   logic                 skid_vld_q, skid_vld_d;
   logic [2:0]           flush_cnt_q, flush_cnt_d;
   logic                 ovf_q, ovf_d;
   logic [31:0]          cnt_q, cnt_d;
   logic                 rf_we_q, rf_we_d;
   logic [4:0]           rf_rd_q, rf_rd_d;
   logic [WORD_W-1:0]    rf_data_q, rf_data_d;
   logic [ROB_IDX_W-1:0] rf_pos_q, rf_pos_d;
   logic                 st_commit_q, st_commit_d;
   logic                 redir_q, redir_d;
   logic [WORD_W-1:0]    redir_a_q, redir_a_d;
   logic                 take;

   always_comb begin
      in_ent = '{rd: rd_in, res: res_in, pos: rob_pos_in, is_store: is_store_in,
                 jump_en: jump_en_in, jump_a: jump_a_in};
   end

   always_comb begin
      state_d     = state_q;
      skid_d      = skid_q;
      skid_vld_d  = skid_vld_q;
      flush_cnt_d = flush_cnt_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      rf_we_d     = 1'b0;
      rf_rd_d     = rf_rd_q;
      rf_data_d   = rf_data_q;
      rf_pos_d    = rf_pos_q;
      st_commit_d = 1'b0;
      redir_d     = 1'b0;
      redir_a_d   = redir_a_q;
      cur         = in_ent;
      take        = 1'b0;
      if (rdy_in) begin
         case (state_q)
            RUN: begin
               // A buffered commit always goes first; a new pulse colliding with it is lost.
               if (skid_vld_q) begin
                  cur        = skid_q;
                  take       = 1'b1;
                  skid_vld_d = 1'b0;
                  if (rob_commit_en_in) ovf_d = 1'b1;
               end else if (rob_commit_en_in) begin
                  take = 1'b1;
               end
               if (take) begin
                  cnt_d = cnt_q + 32'd1;
                  if (cur.rd != 5'd0 && !cur.is_store) begin
                     rf_we_d   = 1'b1;
                     rf_rd_d   = cur.rd;
                     rf_data_d = cur.res;
                     rf_pos_d  = cur.pos;
                  end
                  if (cur.is_store) st_commit_d = 1'b1;
                  if (cur.jump_en) begin
                     redir_d     = 1'b1;
                     redir_a_d   = cur.jump_a;
                     state_d     = FLUSH;
                     flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                     skid_vld_d  = 1'b0;
                  end else if (cur.is_store) begin
                     state_d = STORE_WAIT;
                  end
               end
            end
            STORE_WAIT: begin
               if (lsb_store_done_in) state_d = RUN;
               if (rob_commit_en_in) begin
                  if (skid_vld_q) begin
                     ovf_d = 1'b1;
                  end else begin
                     skid_d     = in_ent;
                     skid_vld_d = 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt_q == 3'd0) state_d = RUN;
               else flush_cnt_d = flush_cnt_q - 3'd1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= RUN;
         skid_q      <= '0;
         skid_vld_q  <= 1'b0;
         flush_cnt_q <= 3'd0;
         ovf_q       <= 1'b0;
         cnt_q       <= 32'd0;
         rf_we_q     <= 1'b0;
         rf_rd_q     <= 5'd0;
         rf_data_q   <= '0;
         rf_pos_q    <= '0;
         st_commit_q <= 1'b0;
         redir_q     <= 1'b0;
         redir_a_q   <= '0;
      end else begin
         state_q     <= state_d;
         skid_q      <= skid_d;
         skid_vld_q  <= skid_vld_d;
         flush_cnt_q <= flush_cnt_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         rf_we_q     <= rf_we_d;
         rf_rd_q     <= rf_rd_d;
         rf_data_q   <= rf_data_d;
         rf_pos_q    <= rf_pos_d;
         st_commit_q <= st_commit_d;
         redir_q     <= redir_d;
         redir_a_q   <= redir_a_d;
      end
   end

   assign commit_stall_out     = (state_q != RUN) || skid_vld_q;
   assign rf_we_out            = rf_we_q;
   assign rf_rd_out            = rf_rd_q;
   assign rf_data_out          = rf_data_q;
   assign rf_rob_pos_out       = rf_pos_q;
   assign lsb_store_commit_out = st_commit_q;
   assign redirect_en_out      = redir_q;
   assign redirect_a_out       = redir_a_q;
   assign clear_branch_out     = (state_q == FLUSH);
   assign skid_overflow_out    = ovf_q;
   assign commit_cnt_out       = cnt_q;

endmodule

// File: doc/commit_ctrl.md
COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 SHALL have parameter ROB_IDX_W, default 4, ROB entry index width.
REQ-002 SHALL have parameter WORD_W, default 32, data and address width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, clear_branch_out hold length (1..7).
REQ-004 SHALL have ports in this order:
- clk_in  in  1  sole clock, all state on rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; 0 freezes block
- rob_commit_en_in  in  1  one-cycle commit pulse from ROB head
- rob_pos_in  in  ROB_IDX_W  committing entry index
- rd_in  in  5  destination register
- res_in  in  WORD_W  result value
- is_store_in  in  1  entry is a store
- jump_en_in  in  1  entry requires PC redirect (mispredict)
- jump_a_in  in  WORD_W  redirect target
- lsb_store_done_in  in  1  LSB finished the committed store
- commit_stall_out  out  1  ROB must not issue a commit next cycle
- rf_we_out  out  1  regfile write pulse
- rf_rd_out  out  5  write register
- rf_data_out  out  WORD_W  write data
- rf_rob_pos_out  out  ROB_IDX_W  tag to release in rename table
- lsb_store_commit_out  out  1  one-cycle store-release pulse
- redirect_en_out  out  1  one-cycle PC redirect pulse
- redirect_a_out  out  WORD_W  redirect target
- clear_branch_out  out  1  pipeline flush
- skid_overflow_out  out  1  sticky protocol-error flag
- commit_cnt_out  out  32  committed-instruction count

Function
REQ-005 SHALL implement states RUN, STORE_WAIT, FLUSH; commit_stall_out = (state != RUN) or skid valid.
REQ-006 SHALL, in RUN, process an accepted commit (input pulse, else skid entry, input has priority only when skid empty) with outputs registered: effects visible the cycle after acceptance.
REQ-007 SHALL pulse rf_we_out for one cycle with rd/res/rob_pos when rd_in != 0 and not store; rd_in == 0 gives no write.
REQ-008 SHALL, for a store, pulse lsb_store_commit_out one cycle and enter STORE_WAIT on the same edge.
REQ-009 SHALL leave STORE_WAIT for RUN on the edge where lsb_store_done_in = 1; done outside STORE_WAIT is ignored.
REQ-010 SHALL, for jump_en_in = 1, pulse redirect_en_out one cycle with redirect_a_out = jump_a_in, perform any rd write on that same cycle, and enter FLUSH.
REQ-011 SHALL hold clear_branch_out high exactly FLUSH_CYCLES cycles starting with the redirect cycle, then return to RUN.
REQ-012 SHALL capture a commit pulse arriving while state != RUN into a 1-entry skid buffer; the skid is processed on the first RUN cycle.
REQ-013 SHALL, on a commit pulse arriving with skid already valid, drop it and set skid_overflow_out (sticky until reset).
REQ-014 SHALL invalidate the skid on entry to FLUSH and ignore commit pulses while clear_branch_out = 1.
REQ-015 SHALL increment commit_cnt_out by 1 per processed commit, wrapping mod 2^32; dropped/flushed commits do not count.
REQ-016 SHALL, when rdy_in = 0, hold state, skid, counter and data outputs, and clear all pulse outputs on that edge; clear_branch_out count is frozen.

Reset
REQ-017 SHALL, on rst_n_in = 0, immediately set state RUN, skid invalid, all 1-bit outputs 0, commit_cnt_out 0, data outputs 0.
REQ-018 SHALL, on reset mid-STORE_WAIT or mid-FLUSH, abandon the operation with no further pulses.

Verification
REQ-019 ALU commit rd=5 res=0x1234 pos=3 -> next cycle rf_we_out=1, rf_rd=5, rf_data=0x1234, rf_rob_pos=3, count 1.
REQ-020 Store commit, done after 4 cycles -> lsb_store_commit_out one pulse, stall high 4 cycles, RUN after done edge.
REQ-021 Mispredict jump_a=0x100 rd=1 -> same cycle rf write and redirect pulse, clear_branch 2 cycles, skid discarded.
REQ-022 Two commits during STORE_WAIT -> first buffered and written after done, second dropped, skid_overflow_out=1.
REQ-023 rd_in=0 commit -> no rf_we_out, count still increments; 2^32-1 counter wraps to 0.
REQ-024 rst_n_in low mid-FLUSH -> clear_branch_out 0 immediately, state RUN after release.
